// File: rtl/spi_tx.sv
// ---------------------------------------------------------------------------
// spi_tx
//
// Purpose:
//   Transmit side of an SPI master. Serialises a packet of (tx_len + 1) bits,
//   MSB first, from a stream of 32-bit words. Words are pulled with a
//   valid/ready handshake. A packet may span any number of words. The
//   external clock generator supplies tx_edge_i, a single-cycle strobe
//   marking each SCLK edge on which the next bit is launched. If the next
//   word is not available at a word boundary, the block stalls. While it
//   stalls, the clock generator holds SCLK.
//
// Ports:
//   clk_i            in   1      rising-edge clock
//   rstn_i           in   1      synchronous active-low reset
//   en_i             in   1      transfer enable; low aborts a packet
//   tx_edge_i        in   1      shift strobe (one clk wide per SCLK edge)
//   sdo_o            out  1      serial data out, MSB first
//   tx_done_o        out  1      pulse on the final bit edge of a packet
//   tx_len_i         in   LEN_W  packet length in bits minus one
//   tx_len_update_i  in   1      load strobe for tx_len_i (IDLE only)
//   tx_data_i        in   32     word to transmit
//   tx_data_vld_i    in   1      word valid
//   tx_data_rdy_o    out  1      word ready
//   tx_stall_o       out  1      high while starved mid-packet
// ---------------------------------------------------------------------------
module spi_tx #(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             tx_edge_i,
    output logic             sdo_o,
    output logic             tx_done_o,
    input  logic [LEN_W-1:0] tx_len_i,
    input  logic             tx_len_update_i,
    input  logic [31:0]      tx_data_i,
    input  logic             tx_data_vld_i,
    output logic             tx_data_rdy_o,
    output logic             tx_stall_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRANSMIT  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      shift_reg;
    logic [LEN_W-1:0] bit_cnt;
    logic [LEN_W-1:0] target;
    logic [4:0]       word_idx;

    logic             last_bit;
    logic             word_end;
    logic             done;

    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    // The bit counter counts edges already consumed in this packet. The
    // packet ends on the edge that consumes bit number "target".
    always_comb begin
        last_bit = (bit_cnt == target);
        word_end = (word_idx == 5'd31);
        // An abort (en_i low) takes precedence, so a packet that is being
        // abandoned never reports completion.
        done     = (state == TRANSMIT) && en_i && tx_edge_i && last_bit;
    end

    // Outputs are decoded from registered state. While rstn_i is low, they
    // are forced to their IDLE values. This keeps them clean from the very
    // first reset cycle, before the state register has been cleared.
    always_comb begin
        sdo_o         = 1'b0;
        tx_done_o     = 1'b0;
        tx_stall_o    = 1'b0;
        tx_data_rdy_o = 1'b1;
        if (rstn_i) begin
            tx_done_o  = done;
            tx_stall_o = (state == WAIT_DATA);
            case (state)
                IDLE: begin
                    sdo_o         = 1'b0;
                    tx_data_rdy_o = 1'b1;
                end
                TRANSMIT: begin
                    sdo_o = shift_reg[31];
                    // The next word is only wanted on the edge that
                    // consumes the last bit of the current word. It is not
                    // wanted if that edge also finishes the packet.
                    tx_data_rdy_o = tx_edge_i && word_end && !done;
                end
                WAIT_DATA: begin
                    sdo_o         = shift_reg[31];
                    tx_data_rdy_o = 1'b1;
                end
                default: begin
                    sdo_o         = 1'b0;
                    tx_data_rdy_o = 1'b1;
                end
            endcase
        end
    end

    // Main FSM with its datapath registers. On every shift edge, the current
    // MSB is considered launched. The register moves left so that the next
    // bit is already on sdo_o before the following edge.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            target    <= '0;
            word_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_len_update_i) begin
                        target <= tx_len_i;
                    end
                    if (en_i && tx_data_vld_i) begin
                        shift_reg <= tx_data_i;
                        bit_cnt   <= '0;
                        word_idx  <= '0;
                        state     <= TRANSMIT;
                    end
                end

                TRANSMIT: begin
                    if (!en_i) begin
                        shift_reg <= '0;
                        state     <= IDLE;
                    end else if (tx_edge_i) begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                        if (last_bit) begin
                            // Any bits left in the current word are dropped.
                            shift_reg <= '0;
                            state     <= IDLE;
                        end else if (word_end) begin
                            word_idx <= '0;
                            if (tx_data_vld_i) begin
                                // Seamless reload: the new MSB goes out on
                                // the very next edge.
                                shift_reg <= tx_data_i;
                            end else begin
                                shift_reg <= {shift_reg[30:0], 1'b0};
                                state     <= WAIT_DATA;
                            end
                        end else begin
                            shift_reg <= {shift_reg[30:0], 1'b0};
                            word_idx  <= word_idx + 5'd1;
                        end
                    end
                end

                WAIT_DATA: begin
                    // Shift edges are ignored here. The bit counter holds,
                    // so the packet resumes exactly where it stalled.
                    if (!en_i) begin
                        shift_reg <= '0;
                        state     <= IDLE;
                    end else if (tx_data_vld_i) begin
                        shift_reg <= tx_data_i;
                        word_idx  <= '0;
                        state     <= TRANSMIT;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx.sv
// ---------------------------------------------------------------------------
// tb_spi_tx
//
// Directed testbench for spi_tx. Each scenario task drives its own stimulus
// and compares outputs against hand-derived values. Inputs change on the
// falling clock edge. Outputs are sampled 1 time unit after that, well away
// from the rising edge.
// ---------------------------------------------------------------------------
module tb_spi_tx;

    logic        clk_i;
    logic        rstn_i;
    logic        en_i;
    logic        tx_edge_i;
    logic        sdo_o;
    logic        tx_done_o;
    logic [15:0] tx_len_i;
    logic        tx_len_update_i;
    logic [31:0] tx_data_i;
    logic        tx_data_vld_i;
    logic        tx_data_rdy_o;
    logic        tx_stall_o;

    int total;
    int bad;

    logic obs_sdo;
    logic obs_done;
    logic obs_rdy;
    logic obs_stall;

    spi_tx #(.LEN_W(16)) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .en_i            (en_i),
        .tx_edge_i       (tx_edge_i),
        .sdo_o           (sdo_o),
        .tx_done_o       (tx_done_o),
        .tx_len_i        (tx_len_i),
        .tx_len_update_i (tx_len_update_i),
        .tx_data_i       (tx_data_i),
        .tx_data_vld_i   (tx_data_vld_i),
        .tx_data_rdy_o   (tx_data_rdy_o),
        .tx_stall_o      (tx_stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Produces one shift strobe and captures the outputs while it is high.
    // A gap cycle follows each strobe. If drop_vld is set, valid is released
    // in that gap cycle.
    task automatic do_edge(input logic drop_vld);
        tx_edge_i = 1'b1;
        #1;
        obs_sdo   = sdo_o;
        obs_done  = tx_done_o;
        obs_rdy   = tx_data_rdy_o;
        obs_stall = tx_stall_o;
        @(negedge clk_i);
        tx_edge_i = 1'b0;
        if (drop_vld) tx_data_vld_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic set_len(input logic [15:0] len);
        tx_len_i        = len;
        tx_len_update_i = 1'b1;
        @(negedge clk_i);
        tx_len_update_i = 1'b0;
    endtask

    task automatic start_word(input logic [31:0] w);
        tx_data_i     = w;
        tx_data_vld_i = 1'b1;
        @(negedge clk_i);
        tx_data_vld_i = 1'b0;
    endtask

    task automatic test_reset;
        rstn_i    = 1'b0;
        tx_edge_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        total++;
        if (sdo_o !== 1'b0 || tx_done_o !== 1'b0 || tx_stall_o !== 1'b0 || tx_data_rdy_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got sdo=%b done=%b stall=%b rdy=%b, want 0 0 0 1",
                     sdo_o, tx_done_o, tx_stall_o, tx_data_rdy_o);
        end
        tx_edge_i = 1'b0;
        rstn_i    = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_8bit;
        logic [7:0] exp_bits;
        exp_bits = 8'b1010_0101;
        en_i = 1'b1;
        set_len(16'd7);
        start_word(32'hA500_0000);
        for (int i = 0; i < 8; i++) begin
            do_edge(1'b0);
            total++;
            if (obs_sdo !== exp_bits[7-i]) begin
                bad++;
                $display("[TB] FAIL p8_sdo bit%0d: got %b want %b", i, obs_sdo, exp_bits[7-i]);
            end
            total++;
            if (obs_done !== (i == 7)) begin
                bad++;
                $display("[TB] FAIL p8_done edge%0d: got %b want %b", i + 1, obs_done, (i == 7));
            end
        end
        #1;
        total++;
        if (sdo_o !== 1'b0 || tx_stall_o !== 1'b0 || tx_data_rdy_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL p8_idle: got sdo=%b stall=%b rdy=%b, want 0 0 1",
                     sdo_o, tx_stall_o, tx_data_rdy_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        exp_bit;
        int          done_cnt;
        w0       = 32'hDEAD_BEEF;
        w1       = 32'h1234_5678;
        done_cnt = 0;
        set_len(16'd63);
        tx_data_i     = w0;
        tx_data_vld_i = 1'b1;
        @(negedge clk_i);
        tx_data_i = w1;
        #1;
        total++;
        if (tx_data_rdy_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_rdy_mid: got %b want 0", tx_data_rdy_o);
        end
        for (int i = 0; i < 64; i++) begin
            do_edge(i == 63);
            exp_bit = (i < 32) ? w0[31-i] : w1[63-i];
            total++;
            if (obs_sdo !== exp_bit) begin
                bad++;
                $display("[TB] FAIL b2b_sdo bit%0d: got %b want %b", i, obs_sdo, exp_bit);
            end
            if (obs_done === 1'b1) done_cnt++;
            if (i == 31) begin
                total++;
                if (obs_rdy !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL b2b_rdy_edge32: got %b want 1", obs_rdy);
                end
            end
            if (i == 63) begin
                total++;
                if (obs_rdy !== 1'b0 || obs_done !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL b2b_last_edge: got rdy=%b done=%b, want 0 1", obs_rdy, obs_done);
                end
            end
        end
        total++;
        if (done_cnt !== 1) begin
            bad++;
            $display("[TB] FAIL b2b_done_count: got %0d want 1", done_cnt);
        end
        #1;
        total++;
        if (sdo_o !== 1'b0 || tx_stall_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_idle: got sdo=%b stall=%b, want 0 0", sdo_o, tx_stall_o);
        end
    endtask

    task automatic test_starve;
        logic [31:0] w0;
        logic [31:0] w1;
        w0 = 32'hF0F0_F0F0;
        w1 = 32'h8000_0001;
        set_len(16'd63);
        start_word(w0);
        for (int i = 0; i < 32; i++) begin
            do_edge(1'b0);
            total++;
            if (obs_sdo !== w0[31-i] || obs_done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL starve_w0 bit%0d: got sdo=%b done=%b want %b 0", i, obs_sdo, obs_done, w0[31-i]);
            end
        end
        #1;
        total++;
        if (tx_stall_o !== 1'b1 || tx_data_rdy_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL starve_wait: got stall=%b rdy=%b want 1 1", tx_stall_o, tx_data_rdy_o);
        end
        for (int i = 0; i < 3; i++) begin
            do_edge(1'b0);
            total++;
            if (obs_done !== 1'b0 || obs_stall !== 1'b1) begin
                bad++;
                $display("[TB] FAIL starve_extra_edge%0d: got done=%b stall=%b want 0 1", i, obs_done, obs_stall);
            end
        end
        start_word(w1);
        #1;
        total++;
        if (tx_stall_o !== 1'b0 || sdo_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL starve_resume: got stall=%b sdo=%b want 0 1", tx_stall_o, sdo_o);
        end
        for (int i = 0; i < 32; i++) begin
            do_edge(1'b0);
            total++;
            if (obs_sdo !== w1[31-i] || obs_done !== (i == 31)) begin
                bad++;
                $display("[TB] FAIL starve_w1 bit%0d: got sdo=%b done=%b want %b %b",
                         i, obs_sdo, obs_done, w1[31-i], (i == 31));
            end
        end
    endtask

    task automatic test_one_bit;
        set_len(16'd0);
        start_word(32'h8000_0000);
        #1;
        total++;
        if (sdo_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL one_bit_sdo: got %b want 1", sdo_o);
        end
        do_edge(1'b0);
        total++;
        if (obs_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL one_bit_done: got %b want 1", obs_done);
        end
        #1;
        total++;
        if (sdo_o !== 1'b0 || tx_stall_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL one_bit_idle: got sdo=%b stall=%b want 0 0", sdo_o, tx_stall_o);
        end
    endtask

    task automatic test_abort;
        logic [7:0] exp_bits;
        exp_bits = 8'b0011_1100;
        set_len(16'd31);
        start_word(32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            do_edge(1'b0);
            total++;
            if (obs_sdo !== 1'b1 || obs_done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL abort_pre edge%0d: got sdo=%b done=%b want 1 0", i + 1, obs_sdo, obs_done);
            end
        end
        en_i = 1'b0;
        #1;
        total++;
        if (tx_done_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_no_done: got %b want 0", tx_done_o);
        end
        @(negedge clk_i);
        #1;
        total++;
        if (sdo_o !== 1'b0 || tx_stall_o !== 1'b0 || tx_data_rdy_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL abort_idle: got sdo=%b stall=%b rdy=%b want 0 0 1",
                     sdo_o, tx_stall_o, tx_data_rdy_o);
        end
        en_i = 1'b1;
        set_len(16'd7);
        start_word(32'h3C00_0000);
        for (int i = 0; i < 8; i++) begin
            do_edge(1'b0);
            total++;
            if (obs_sdo !== exp_bits[7-i] || obs_done !== (i == 7)) begin
                bad++;
                $display("[TB] FAIL abort_next bit%0d: got sdo=%b done=%b want %b %b",
                         i, obs_sdo, obs_done, exp_bits[7-i], (i == 7));
            end
        end
    endtask

    task automatic test_reset_midpacket;
        set_len(16'd31);
        start_word(32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) do_edge(1'b0);
        rstn_i    = 1'b0;
        tx_edge_i = 1'b1;
        #1;
        total++;
        if (sdo_o !== 1'b0 || tx_done_o !== 1'b0 || tx_stall_o !== 1'b0 || tx_data_rdy_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_outputs: got sdo=%b done=%b stall=%b rdy=%b want 0 0 0 1",
                     sdo_o, tx_done_o, tx_stall_o, tx_data_rdy_o);
        end
        @(negedge clk_i);
        rstn_i    = 1'b1;
        tx_edge_i = 1'b0;
        #1;
        total++;
        if (sdo_o !== 1'b0 || tx_stall_o !== 1'b0 || tx_data_rdy_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_after: got sdo=%b stall=%b rdy=%b want 0 0 1",
                     sdo_o, tx_stall_o, tx_data_rdy_o);
        end
        @(negedge clk_i);
        // The target was cleared by reset, so this packet is a single bit.
        start_word(32'h8000_0000);
        do_edge(1'b0);
        total++;
        if (obs_sdo !== 1'b1 || obs_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_target_cleared: got sdo=%b done=%b want 1 1", obs_sdo, obs_done);
        end
    endtask

    task automatic test_len_update;
        logic [7:0] exp_bits;
        exp_bits = 8'b1010_0101;
        set_len(16'd7);
        start_word(32'hA500_0000);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                tx_len_i        = 16'd3;
                tx_len_update_i = 1'b1;
                @(negedge clk_i);
                tx_len_update_i = 1'b0;
            end
            do_edge(1'b0);
            total++;
            if (obs_sdo !== exp_bits[7-i] || obs_done !== (i == 7)) begin
                bad++;
                $display("[TB] FAIL len_update bit%0d: got sdo=%b done=%b want %b %b",
                         i, obs_sdo, obs_done, exp_bits[7-i], (i == 7));
            end
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rstn_i          = 1'b0;
        en_i            = 1'b0;
        tx_edge_i       = 1'b0;
        tx_len_i        = '0;
        tx_len_update_i = 1'b0;
        tx_data_i       = '0;
        tx_data_vld_i   = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_8bit();
        test_back_to_back();
        test_starve();
        test_one_bit();
        test_abort();
        test_reset_midpacket();
        test_len_update();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
